branch_resolve: RTL and testbench

- EX-stage producer of the `ex_bp_info_t` update stream consumed by `branch_predict`.
- For each of two issue lanes per cycle, compares the prediction carried with the instruction (`ptaken`/`ptarget`) against the actual outcome.
- On a mispredict it raises a same-cycle flush of younger work and a registered, handshaked fetch redirect.
- Emits registered BHT/BTB/JTB training info and saturating performance counters.

---
 rtl/super_pkg.sv | 28 ++
 rtl/bp_lane_check.sv | 41 ++++
 rtl/branch_resolve.sv | 151 +++++++++++++++
 tb/tb_branch_resolve.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/super_pkg.sv
// Shared branch-prediction types and helpers for the fetch/EX predictor loop.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package super_pkg;

    // Training record handed from EX back to branch_predict, one slot per lane.
    typedef struct packed {
        logic [1:0]  is_branch;
        logic [1:0]  is_jal;
        logic [1:0]  taken;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [31:0] target0;
        logic [31:0] target1;
    } ex_bp_info_t;

    typedef enum logic {
        IDLE     = 1'b0,
        RED_PEND = 1'b1
    } bp_resolve_state_e;

    // Sequential next PC: compressed instructions are 2 bytes, others 4.
    function automatic logic [31:0] bp_fallthru_pc(input logic [31:0] pc,
                                                   input logic        is_comp);
        return pc + (is_comp ? 32'd2 : 32'd4);
    endfunction

endpackage

// File: rtl/bp_lane_check.sv
// Per-lane mispredict detection and correct next-PC selection.
// Latency: purely combinational.
// Backpressure: none; valid gates only the mispredict flag.
// Ports: valid/pc/is_comp/is_branch/is_jal/ptaken/ptarget/taken/target in;
//        mp (lane mispredicted) and correct_pc (architecturally next PC) out.
module bp_lane_check
    import super_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] pc,
    input  logic        is_comp,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        ptaken,
    input  logic [31:0] ptarget,
    input  logic        taken,
    input  logic [31:0] target,
    output logic        mp,
    output logic [31:0] correct_pc
);

    always_comb begin
        mp         = 1'b0;
        correct_pc = bp_fallthru_pc(pc, is_comp);
        // jal is always taken even if the taken input were not forced upstream
        if (is_jal || (is_branch && taken)) begin
            correct_pc = target;
        end
        if (valid) begin
            if (is_branch) begin
                mp = (ptaken != taken) || (taken && ptaken && (ptarget != target));
            end else if (is_jal) begin
                mp = !ptaken || (ptarget != target);
            end else begin
                // a non-control instruction predicted taken steered fetch wrongly
                mp = ptaken;
            end
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: flush, fetch redirect, predictor training, perf counters.
// Latency: flush_o same cycle; redirect, training info and counters one cycle after resolve.
// Backpressure: redirect held until redirect_ready_i; resolve_stall_o holds EX meanwhile.
// Ports: clk_i/rst_i; two-lane ex_* resolve inputs; ex_bp_info_o training record;
//        flush_o; redirect_valid_o/redirect_target_o/redirect_ready_i handshake;
//        resolve_stall_o; branch_cnt_o/mispredict_cnt_o saturating counters.
module branch_resolve
    import super_pkg::*;
#(
    parameter int CntWidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          ex_valid_i,
    input  logic [31:0]         ex_pc0_i,
    input  logic [31:0]         ex_pc1_i,
    input  logic [1:0]          ex_is_comp_i,
    input  logic [1:0]          ex_is_branch_i,
    input  logic [1:0]          ex_is_jal_i,
    input  logic [1:0]          ex_ptaken_i,
    input  logic [31:0]         ex_ptarget0_i,
    input  logic [31:0]         ex_ptarget1_i,
    input  logic [1:0]          ex_taken_i,
    input  logic [31:0]         ex_target0_i,
    input  logic [31:0]         ex_target1_i,
    output ex_bp_info_t         ex_bp_info_o,
    output logic [1:0]          flush_o,
    output logic                redirect_valid_o,
    output logic [31:0]         redirect_target_o,
    input  logic                redirect_ready_i,
    output logic                resolve_stall_o,
    output logic [CntWidth-1:0] branch_cnt_o,
    output logic [CntWidth-1:0] mispredict_cnt_o
);

    bp_resolve_state_e   state_q;
    logic                red_vld_q;
    logic [31:0]         red_tgt_q;
    ex_bp_info_t         info_q;
    ex_bp_info_t         info_d;
    logic [CntWidth-1:0] bcnt_q;
    logic [CntWidth-1:0] mcnt_q;
    logic [CntWidth-1:0] bcnt_d;
    logic [CntWidth-1:0] mcnt_d;
    logic [CntWidth:0]   bcnt_sum;

    logic [1:0]  v;
    logic [1:0]  mp;
    logic [1:0]  squash;
    logic [1:0]  trained;
    logic [1:0]  n_train;
    logic [31:0] cpc0;
    logic [31:0] cpc1;

    // Anything arriving while a redirect is pending is wrong-path.
    assign v = ex_valid_i & {2{state_q == IDLE}};

    bp_lane_check u_lane0 (
        .valid      (v[0]),
        .pc         (ex_pc0_i),
        .is_comp    (ex_is_comp_i[0]),
        .is_branch  (ex_is_branch_i[0]),
        .is_jal     (ex_is_jal_i[0]),
        .ptaken     (ex_ptaken_i[0]),
        .ptarget    (ex_ptarget0_i),
        .taken      (ex_taken_i[0]),
        .target     (ex_target0_i),
        .mp         (mp[0]),
        .correct_pc (cpc0)
    );

    // Lane 1 is younger: a lane-0 mispredict makes it wrong-path.
    bp_lane_check u_lane1 (
        .valid      (v[1] & ~mp[0]),
        .pc         (ex_pc1_i),
        .is_comp    (ex_is_comp_i[1]),
        .is_branch  (ex_is_branch_i[1]),
        .is_jal     (ex_is_jal_i[1]),
        .ptaken     (ex_ptaken_i[1]),
        .ptarget    (ex_ptarget1_i),
        .taken      (ex_taken_i[1]),
        .target     (ex_target1_i),
        .mp         (mp[1]),
        .correct_pc (cpc1)
    );

    assign squash  = {mp[0], 1'b0};
    assign trained = v & (ex_is_branch_i | ex_is_jal_i) & ~squash;
    assign n_train = {1'b0, trained[0]} + {1'b0, trained[1]};

    assign flush_o = mp[0] ? 2'b11 : (mp[1] ? 2'b10 : 2'b00);

    always_comb begin
        info_d           = '0;
        info_d.is_branch = v & ex_is_branch_i & ~squash;
        info_d.is_jal    = v & ex_is_jal_i & ~squash;
        info_d.taken     = ex_taken_i & trained;
        info_d.pc0       = trained[0] ? ex_pc0_i : 32'd0;
        info_d.pc1       = trained[1] ? ex_pc1_i : 32'd0;
        info_d.target0   = trained[0] ? ex_target0_i : 32'd0;
        info_d.target1   = trained[1] ? ex_target1_i : 32'd0;
    end

    // One extra bit catches the carry so the counter pins at all-ones.
    assign bcnt_sum = {1'b0, bcnt_q} + {{(CntWidth-1){1'b0}}, n_train};
    assign bcnt_d   = bcnt_sum[CntWidth] ? {CntWidth{1'b1}} : bcnt_sum[CntWidth-1:0];
    assign mcnt_d   = (mcnt_q == {CntWidth{1'b1}}) ? mcnt_q
                                                   : mcnt_q + {{(CntWidth-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            red_vld_q <= 1'b0;
            red_tgt_q <= 32'd0;
            info_q    <= '0;
            bcnt_q    <= '0;
            mcnt_q    <= '0;
        end else begin
            info_q <= info_d;
            bcnt_q <= bcnt_d;
            case (state_q)
                IDLE: begin
                    if (|mp) begin
                        state_q   <= RED_PEND;
                        red_vld_q <= 1'b1;
                        red_tgt_q <= mp[0] ? cpc0 : cpc1;
                        mcnt_q    <= mcnt_d;
                    end
                end
                RED_PEND: begin
                    if (redirect_ready_i) begin
                        state_q   <= IDLE;
                        red_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    red_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign ex_bp_info_o      = info_q;
    assign redirect_valid_o  = red_vld_q;
    assign resolve_stall_o   = red_vld_q;
    assign redirect_target_o = red_tgt_q;
    assign branch_cnt_o      = bcnt_q;
    assign mispredict_cnt_o  = mcnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random traffic
// compared every cycle against a rule-level model of the resolve behaviour.
module tb_branch_resolve;
    import super_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [1:0]        a_v, a_comp, a_br, a_jal, a_ptk, a_tk;
    logic [31:0]       a_pc [2];
    logic [31:0]       a_pt [2];
    logic [31:0]       a_tg [2];
    logic              ready;

    ex_bp_info_t       info;
    logic [1:0]        flush;
    logic              rvld, stall;
    logic [31:0]       rtgt;
    logic [CW-1:0]     bcnt, mcnt;

    branch_resolve #(.CntWidth(CW)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ex_valid_i        (a_v),
        .ex_pc0_i          (a_pc[0]),
        .ex_pc1_i          (a_pc[1]),
        .ex_is_comp_i      (a_comp),
        .ex_is_branch_i    (a_br),
        .ex_is_jal_i       (a_jal),
        .ex_ptaken_i       (a_ptk),
        .ex_ptarget0_i     (a_pt[0]),
        .ex_ptarget1_i     (a_pt[1]),
        .ex_taken_i        (a_tk),
        .ex_target0_i      (a_tg[0]),
        .ex_target1_i      (a_tg[1]),
        .ex_bp_info_o      (info),
        .flush_o           (flush),
        .redirect_valid_o  (rvld),
        .redirect_target_o (rtgt),
        .redirect_ready_i  (ready),
        .resolve_stall_o   (stall),
        .branch_cnt_o      (bcnt),
        .mispredict_cnt_o  (mcnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;
    logic [1:0] s_flush;

    // model state
    bit          m_pend;
    logic [31:0] m_tgt;
    ex_bp_info_t m_info;
    int          m_bcnt, m_mcnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Outcome of one lane by the resolution rules, ignoring validity.
    function automatic void lane_model(input int ln, output bit mp, output logic [31:0] npc);
        logic [31:0] ft;
        ft = a_pc[ln] + (a_comp[ln] ? 32'd2 : 32'd4);
        if (a_jal[ln]) begin
            mp  = !a_ptk[ln] || (a_pt[ln] != a_tg[ln]);
            npc = a_tg[ln];
        end else if (a_br[ln]) begin
            mp  = (a_ptk[ln] != a_tk[ln]) || (a_tk[ln] && a_ptk[ln] && a_pt[ln] != a_tg[ln]);
            npc = a_tk[ln] ? a_tg[ln] : ft;
        end else begin
            mp  = a_ptk[ln];
            npc = ft;
        end
    endfunction

    function automatic void resolve(output bit mp0, output bit mp1,
                                    output logic [31:0] n0, output logic [31:0] n1,
                                    output bit tr0, output bit tr1);
        bit l0, l1, idle, ok1;
        idle = !m_pend;
        lane_model(0, l0, n0);
        lane_model(1, l1, n1);
        mp0 = idle && a_v[0] && l0;
        ok1 = idle && a_v[1] && !mp0;
        mp1 = ok1 && l1;
        tr0 = idle && a_v[0] && (a_br[0] || a_jal[0]);
        tr1 = ok1 && (a_br[1] || a_jal[1]);
    endfunction

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic model_clock();
        bit mp0, mp1, tr0, tr1;
        logic [31:0] n0, n1;
        if (rst) begin
            m_pend = 0; m_tgt = 0; m_info = '0; m_bcnt = 0; m_mcnt = 0;
        end else begin
            resolve(mp0, mp1, n0, n1, tr0, tr1);
            m_info           = '0;
            m_info.is_branch = {tr1 && a_br[1], tr0 && a_br[0]};
            m_info.is_jal    = {tr1 && a_jal[1], tr0 && a_jal[0]};
            m_info.taken     = {tr1 && a_tk[1], tr0 && a_tk[0]};
            if (tr0) begin m_info.pc0 = a_pc[0]; m_info.target0 = a_tg[0]; end
            if (tr1) begin m_info.pc1 = a_pc[1]; m_info.target1 = a_tg[1]; end
            m_bcnt = sat(m_bcnt + int'(tr0) + int'(tr1));
            if (m_pend) begin
                if (ready) m_pend = 0;
            end else if (mp0 || mp1) begin
                m_pend = 1;
                m_tgt  = mp0 ? n0 : n1;
                m_mcnt = sat(m_mcnt + 1);
            end
        end
    endtask

    // Called just after inputs are driven near the falling edge.
    task automatic step();
        bit mp0, mp1, tr0, tr1;
        logic [31:0] n0, n1;
        #1;
        s_flush = flush;
        if (chk_en) begin
            resolve(mp0, mp1, n0, n1, tr0, tr1);
            chk("flush", 32'(flush), mp0 ? 32'd3 : (mp1 ? 32'd2 : 32'd0));
            chk("redirect_valid", 32'(rvld), 32'(m_pend));
            chk("resolve_stall", 32'(stall), 32'(m_pend));
            chk("redirect_target", rtgt, m_tgt);
            chk("info.is_branch", 32'(info.is_branch), 32'(m_info.is_branch));
            chk("info.is_jal", 32'(info.is_jal), 32'(m_info.is_jal));
            chk("info.taken", 32'(info.taken), 32'(m_info.taken));
            chk("info.pc0", info.pc0, m_info.pc0);
            chk("info.pc1", info.pc1, m_info.pc1);
            chk("info.target0", info.target0, m_info.target0);
            chk("info.target1", info.target1, m_info.target1);
            chk("branch_cnt", 32'(bcnt), 32'(m_bcnt));
            chk("mispredict_cnt", 32'(mcnt), 32'(m_mcnt));
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic clr();
        a_v = 0; a_comp = 0; a_br = 0; a_jal = 0; a_ptk = 0; a_tk = 0;
        for (int i = 0; i < 2; i++) begin a_pc[i] = 0; a_pt[i] = 0; a_tg[i] = 0; end
    endtask

    task automatic set_lane(input int ln, input logic [31:0] pc, input bit comp,
                            input bit br, input bit jal, input bit ptk,
                            input logic [31:0] pt, input bit tk, input logic [31:0] tg);
        a_v[ln] = 1; a_pc[ln] = pc; a_comp[ln] = comp; a_br[ln] = br; a_jal[ln] = jal;
        a_ptk[ln] = ptk; a_pt[ln] = pt; a_tk[ln] = tk; a_tg[ln] = tg;
    endtask

    task automatic rand_lane(input int ln);
        int kind;
        logic [31:0] tg;
        kind = int'($urandom_range(0, 2));
        tg   = $urandom & 32'hFFFF_FFFE;
        a_v[ln]    = $urandom_range(0, 3) != 0;
        a_pc[ln]   = $urandom & 32'hFFFF_FFFE;
        a_comp[ln] = $urandom_range(0, 1) == 1;
        a_br[ln]   = kind == 1;
        a_jal[ln]  = kind == 2;
        a_ptk[ln]  = (kind == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
        a_tk[ln]   = (kind == 2) || (kind == 1 && $urandom_range(0, 1) == 1);
        a_tg[ln]   = tg;
        a_pt[ln]   = ($urandom_range(0, 3) != 0) ? tg : ($urandom & 32'hFFFF_FFFE);
    endtask

    initial begin
        clr(); ready = 0; rst = 1;
        m_pend = 0; m_tgt = 0; m_info = '0; m_bcnt = 0; m_mcnt = 0;
        @(negedge clk);
        step();
        chk_en = 1;
        step();
        rst = 0;
        chk("reset redirect_valid", 32'(rvld), 32'd0);
        chk("reset branch_cnt", 32'(bcnt), 32'd0);
        chk("reset info", 32'(info.is_branch | info.is_jal), 32'd0);

        // correctly predicted taken branch
        set_lane(0, 32'h100, 0, 1, 0, 1, 32'h140, 1, 32'h140);
        step();
        chk("t1 flush", 32'(s_flush), 32'd0);
        chk("t1 redirect_valid", 32'(rvld), 32'd0);
        chk("t1 is_branch", 32'(info.is_branch), 32'd1);
        chk("t1 taken", 32'(info.taken), 32'd1);
        chk("t1 target0", info.target0, 32'h140);
        chk("t1 branch_cnt", 32'(bcnt), 32'd1);
        clr();

        // compressed branch predicted taken, falls through; lane 1 wrong-path
        set_lane(0, 32'h200, 1, 1, 0, 1, 32'h240, 0, 32'h240);
        set_lane(1, 32'h202, 0, 1, 0, 0, 32'h0, 0, 32'h300);
        step();
        chk("t2 flush", 32'(s_flush), 32'd3);
        chk("t2 redirect_valid", 32'(rvld), 32'd1);
        chk("t2 redirect_target", rtgt, 32'h202);
        chk("t2 is_branch", 32'(info.is_branch), 32'd1);
        chk("t2 mispredict_cnt", 32'(mcnt), 32'd1);
        clr(); ready = 1; step(); ready = 0;

        // lane 1 jal predicted not-taken
        set_lane(0, 32'h300, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        set_lane(1, 32'h304, 0, 0, 1, 0, 32'h0, 1, 32'h400);
        step();
        chk("t3 flush", 32'(s_flush), 32'd2);
        chk("t3 redirect_target", rtgt, 32'h400);
        chk("t3 is_jal", 32'(info.is_jal), 32'd2);
        chk("t3 target1", info.target1, 32'h400);
        clr(); ready = 1; step(); ready = 0;

        // both lanes mispredict; lane 0 wins; redirect held three cycles
        set_lane(0, 32'h500, 0, 1, 0, 0, 32'h0, 1, 32'h600);
        set_lane(1, 32'h504, 0, 0, 1, 0, 32'h0, 1, 32'h700);
        step();
        chk("t4 flush", 32'(s_flush), 32'd3);
        chk("t4 redirect_target", rtgt, 32'h600);
        chk("t4 mispredict_cnt", 32'(mcnt), 32'd3);
        chk("t4 branch_cnt", 32'(bcnt), 32'd4);
        for (int i = 0; i < 3; i++) begin
            set_lane(0, 32'h900, 0, 1, 0, 1, 32'h0, 0, 32'h0);
            set_lane(1, 32'h904, 0, 1, 0, 0, 32'h0, 0, 32'h0);
            step();
            chk("t4 hold flush", 32'(s_flush), 32'd0);
            chk("t4 hold valid", 32'(rvld), 32'd1);
            chk("t4 hold stall", 32'(stall), 32'd1);
            chk("t4 hold target", rtgt, 32'h600);
            chk("t4 hold branch_cnt", 32'(bcnt), 32'd4);
            chk("t4 hold mispredict_cnt", 32'(mcnt), 32'd3);
            chk("t4 hold info", 32'(info.is_branch), 32'd0);
        end
        clr(); ready = 1; step(); ready = 0;
        chk("t4 released", 32'(rvld), 32'd0);

        // reset while a redirect is pending
        set_lane(0, 32'h800, 0, 0, 0, 1, 32'h0, 0, 32'h0);
        step();
        chk("t5 pending", 32'(rvld), 32'd1);
        clr(); rst = 1; step(); rst = 0;
        chk("t5 redirect_valid", 32'(rvld), 32'd0);
        chk("t5 branch_cnt", 32'(bcnt), 32'd0);
        chk("t5 mispredict_cnt", 32'(mcnt), 32'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rand_lane(0);
            rand_lane(1);
            ready = $urandom_range(0, 2) == 0;
            rst   = $urandom_range(0, 149) == 0;
            step();
        end
        rst = 0; ready = 0; clr();

        // counter saturation at all-ones
        rst = 1; step(); rst = 0;
        for (int i = 0; i < CMAX - 1; i++) begin
            set_lane(0, 32'h1000, 0, 1, 0, 0, 32'h0, 0, 32'h2000);
            step();
        end
        chk("sat pre", 32'(bcnt), 32'(CMAX - 1));
        set_lane(0, 32'h1000, 0, 1, 0, 0, 32'h0, 0, 32'h2000);
        set_lane(1, 32'h1004, 0, 1, 0, 0, 32'h0, 0, 32'h3000);
        step();
        chk("sat hit", 32'(bcnt), 32'(CMAX));
        step();
        chk("sat hold", 32'(bcnt), 32'(CMAX));
        clr(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
